muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide unit sitting beside the ALU in the EXE stage. It consumes the forwarded operands latched by the ID/EXE pipeline registers and owns the HI/LO register pair. HI/LO is presented as the 64-bit result that travels through the EXE/MEM and MEM/WB pipeline registers to write-back. While an operation is in flight it raises `busy`, and the hazard logic in ID uses it to stall.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_step.sv | 40 ++++
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Op encodings, FSM states and iteration count.
package muldiv_pkg;

  localparam int MULDIV_ITER = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One shift-add (multiply) or restore-subtract (divide) iteration.
// Divide path only exists when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = MULDIV_ITER
) (
`ifdef MULDIV_DIV_EN
  input  logic              mul_i,
`endif
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] mul_nx;

  assign sum = {1'b0, acc_i[2*XLEN-1:XLEN]}
             + (acc_i[0] ? {1'b0, opnd_i} : '0);
  assign mul_nx = {sum, acc_i[XLEN-1:1]};

`ifdef MULDIV_DIV_EN
  logic [XLEN:0]     rem_sh;
  logic              ge;
  logic [XLEN-1:0]   rem_nx;
  logic [2*XLEN-1:0] div_nx;

  // Remainder in the upper half, dividend shifts out of the lower half
  assign rem_sh = acc_i[2*XLEN-1:XLEN-1];
  assign ge     = rem_sh >= {1'b0, opnd_i};
  assign rem_nx = XLEN'(rem_sh - {1'b0, opnd_i});
  assign div_nx = ge ? {rem_nx, acc_i[XLEN-2:0], 1'b1}
                     : {acc_i[2*XLEN-2:0], 1'b0};
  assign acc_o  = mul_i ? mul_nx : div_nx;
`else
  assign acc_o  = mul_nx;
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO (EXE stage).
// Define MULDIV_DIV_EN to build DIV/DIVU support.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = MULDIV_ITER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              cancel,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   hi,
  output logic [XLEN-1:0]   lo,
  output logic [2*XLEN-1:0] hilo
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              neg_q, neg_d;
  logic              done_q, done_d;

  logic              sgn;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] prod, step_acc;

  assign sgn   = (op == OP_MULT) || (op == OP_DIV);
  assign a_mag = (sgn && a[XLEN-1]) ? -a : a;
  assign b_mag = (sgn && b[XLEN-1]) ? -b : b;
  assign prod  = neg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
  logic            div_q, div_d;
  logic            rneg_q, rneg_d;
  logic            dz_q, dz_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] quo, rem;

  assign quo = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem = rneg_q ? -acc_q[2*XLEN-1:XLEN]
                      : acc_q[2*XLEN-1:XLEN];
`endif

  muldiv_step #(.XLEN(XLEN)) u_step (
`ifdef MULDIV_DIV_EN
    .mul_i  (!div_q),
`endif
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
    div_d   = div_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    a_d     = a_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              acc_d   = {{XLEN{1'b0}}, b_mag};
              opnd_d  = a_mag;
              neg_d   = sgn & (a[XLEN-1] ^ b[XLEN-1]);
              cnt_d   = '0;
              state_d = S_RUN;
`ifdef MULDIV_DIV_EN
              div_d   = 1'b0;
`endif
            end
`ifdef MULDIV_DIV_EN
            OP_DIV, OP_DIVU: begin
              acc_d   = {{XLEN{1'b0}}, a_mag};
              opnd_d  = b_mag;
              neg_d   = sgn & (a[XLEN-1] ^ b[XLEN-1]);
              rneg_d  = sgn & a[XLEN-1];
              dz_d    = (b == '0);
              a_d     = a;
              div_d   = 1'b1;
              cnt_d   = '0;
              state_d = S_RUN;
            end
`endif
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
`ifdef MULDIV_DIV_EN
          if (div_q && dz_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else if (div_q) begin
            hi_d = rem;
            lo_d = quo;
          end else
`endif
          begin
            hi_d = prod[2*XLEN-1:XLEN];
            lo_d = prod[XLEN-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      a_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
`ifdef MULDIV_DIV_EN
      div_q   <= div_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      a_q     <= a_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign hilo = {hi_q, lo_q};

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit.
// Expectations follow MULDIV_DIV_EN when it is defined.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cancel = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [63:0] hilo;

  int nvec = 0;
  int nfail = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          cyc;
  } vec_t;

  vec_t vt[$];

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo),
    .hilo   (hilo)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [2:0] o, logic [31:0] x,
                              logic [31:0] y, logic [31:0] h,
                              logic [31:0] l, int c);
    vec_t v;
    v.op = o; v.a = x; v.b = y;
    v.ehi = h; v.elo = l; v.cyc = c;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(logic [2:0] o, logic [31:0] x, logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;

    vt.push_back(mk(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'hFFFFFFFE, 32'h00000001, 33));
    vt.push_back(mk(OP_MULT, 32'hFFFFFFFD, 32'd7,
                    32'hFFFFFFFF, 32'hFFFFFFEB, 33));
    vt.push_back(mk(OP_MTLO, 32'h12345678, 32'd0,
                    32'hFFFFFFFF, 32'h12345678, 0));
    vt.push_back(mk(OP_MTHI, 32'hAAAA0000, 32'd0,
                    32'hAAAA0000, 32'h12345678, 0));
    vt.push_back(mk(OP_MULT, 32'h80000000, 32'h80000000,
                    32'h40000000, 32'h00000000, 33));
    vt.push_back(mk(OP_MULT, 32'd5, 32'hFFFFFFFA,
                    32'hFFFFFFFF, 32'hFFFFFFE2, 33));
    vt.push_back(mk(OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF,
                    32'h3FFFFFFF, 32'h00000001, 33));
    vt.push_back(mk(OP_MULTU, 32'h12345678, 32'd0,
                    32'h0, 32'h0, 33));
    vt.push_back(mk(OP_MTHI, 32'h0000DEAD, 32'd0,
                    32'h0000DEAD, 32'h0, 0));
    vt.push_back(mk(OP_MTLO, 32'h0000BEEF, 32'd0,
                    32'h0000DEAD, 32'h0000BEEF, 0));
    vt.push_back(mk(3'd6, 32'h1, 32'h2,
                    32'h0000DEAD, 32'h0000BEEF, 0));
    vt.push_back(mk(3'd7, 32'h3, 32'h4,
                    32'h0000DEAD, 32'h0000BEEF, 0));
`ifdef MULDIV_DIV_EN
    vt.push_back(mk(OP_DIV, 32'hFFFFFFF9, 32'd2,
                    32'hFFFFFFFF, 32'hFFFFFFFD, 33));
    vt.push_back(mk(OP_DIVU, 32'd100, 32'd0,
                    32'd100, 32'hFFFFFFFF, 33));
    vt.push_back(mk(OP_DIV, 32'd7, 32'hFFFFFFFE,
                    32'd1, 32'hFFFFFFFD, 33));
    vt.push_back(mk(OP_DIVU, 32'hFFFFFFFF, 32'd16,
                    32'd15, 32'h0FFFFFFF, 33));
`else
    vt.push_back(mk(OP_DIV, 32'hFFFFFFF9, 32'd2,
                    32'h0000DEAD, 32'h0000BEEF, 0));
    vt.push_back(mk(OP_DIVU, 32'd100, 32'd0,
                    32'h0000DEAD, 32'h0000BEEF, 0));
    vt.push_back(mk(OP_DIV, 32'd7, 32'hFFFFFFFE,
                    32'h0000DEAD, 32'h0000BEEF, 0));
    vt.push_back(mk(OP_DIVU, 32'hFFFFFFFF, 32'd16,
                    32'h0000DEAD, 32'h0000BEEF, 0));
`endif
    vt.push_back(mk(OP_MTHI, 32'h11, 32'd0, 32'h11, 32'h0000BEEF, 0));
    vt.push_back(mk(OP_MTLO, 32'h22, 32'd0, 32'h11, 32'h22, 0));

    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hilo", hilo, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle hilo", hilo, 64'd0);

    for (int i = 0; i < vt.size(); i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b);
      if (vt[i].cyc > 0) begin
        wait_done(cyc);
        chk($sformatf("v%0d cycles", i), 64'(cyc), 64'(vt[i].cyc));
        chk($sformatf("v%0d done", i), 64'(done), 64'd1);
      end else begin
        chk($sformatf("v%0d busy", i), 64'(busy), 64'd0);
        chk($sformatf("v%0d done", i), 64'(done), 64'd0);
      end
      chk($sformatf("v%0d hi", i), 64'(hi), 64'(vt[i].ehi));
      chk($sformatf("v%0d lo", i), 64'(lo), 64'(vt[i].elo));
      chk($sformatf("v%0d hilo", i), hilo, {vt[i].ehi, vt[i].elo});
      @(negedge clk);
      chk($sformatf("v%0d done clr", i), 64'(done), 64'd0);
    end

    // start while busy is ignored, MTHI included
    issue(OP_MULTU, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    start = 1'b1; op = OP_MTHI; a = 32'hFFFF;
    @(negedge clk);
    start = 1'b0;
    chk("ign hi mid", 64'(hi), 64'h11);
    wait_done(cyc);
    chk("ign cycles", 64'(cyc), 64'd23);
    chk("ign done", 64'(done), 64'd1);
    chk("ign hilo", hilo, {32'h0, 32'd30});

    // cancel mid-run
    issue(OP_MTHI, 32'hAAAA0000, 32'd0);
    issue(OP_MTLO, 32'h00005555, 32'd0);
    issue(OP_MULT, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    chk("cxl busy pre", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cxl busy", 64'(busy), 64'd0);
    chk("cxl done", 64'(done), 64'd0);
    chk("cxl hilo", hilo, {32'hAAAA0000, 32'h5555});
    @(negedge clk);
    chk("cxl done2", 64'(done), 64'd0);
    chk("cxl hilo2", hilo, {32'hAAAA0000, 32'h5555});

    // cancel with start in idle: nothing starts
    @(negedge clk);
    cancel = 1'b1; start = 1'b1; op = OP_MULT; a = 32'd2; b = 32'd2;
    @(negedge clk);
    chk("cs busy", 64'(busy), 64'd0);
    op = OP_MTHI; a = 32'h999;
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    chk("cs busy2", 64'(busy), 64'd0);
    chk("cs hilo", hilo, {32'hAAAA0000, 32'h5555});

    // reset mid-run
    issue(OP_MULT, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst hilo", hilo, 64'd0);
    repeat (2) @(negedge clk);
    chk("rst busy2", 64'(busy), 64'd0);

    // back-to-back start accepted while done is high
`ifdef MULDIV_DIV_EN
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(cyc);
    chk("ovf hilo", hilo, {32'h0, 32'h80000000});
`else
    issue(OP_MULT, 32'h80000000, 32'd1);
    wait_done(cyc);
    chk("b2b hilo", hilo, {32'hFFFFFFFF, 32'h80000000});
`endif
    chk("b2b cycles", 64'(cyc), 64'd33);
    chk("b2b done", 64'(done), 64'd1);
    start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("b2b busy", 64'(busy), 64'd1);
    chk("b2b done clr", 64'(done), 64'd0);
    wait_done(cyc);
    chk("b2b cycles2", 64'(cyc), 64'd33);
    chk("b2b hilo2", hilo, {32'h0, 32'd6});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
